// File: rtl/fetch_prefetch_buffer_if.sv
// fetch_prefetch_buffer_if: redirect, instruction-memory and decode handshake signals of the fetch unit
interface fetch_prefetch_buffer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  modport master (
    input  redirect, redirect_pc, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst, inst_pc
  );
  modport slave (
    output redirect, redirect_pc, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: fetch PC, 1-cycle instruction-memory reads and a decode-side FIFO with redirect flush
// Define PREFETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_prefetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input logic clk,
  input logic reset,
  fetch_prefetch_buffer_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d, kill_q, kill_d;
  logic [PW:0]       count_q, count_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [DATA_W-1:0] fifo_inst_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q [DEPTH];
  logic              resp, byp, head_v, pop, push;
  assign resp   = inflight_q && !kill_q;
  assign head_v = count_q != '0;
`ifdef PREFETCH_BYPASS_EN
  assign byp = resp && !head_v;
`else
  assign byp = 1'b0;
`endif
  assign pop  = head_v && bus.inst_ready;
  assign push = resp && !(byp && bus.inst_ready);
  // Credit counts the in-flight read so a response always finds a free slot.
  assign bus.mem_req    = !reset && !bus.redirect &&
                          (count_q + (PW+1)'(inflight_q) < (PW+1)'(DEPTH));
  assign bus.mem_addr   = fetch_pc_q;
  assign bus.inst_valid = head_v || byp;
  assign bus.inst       = head_v ? fifo_inst_q[rd_q] : byp ? bus.mem_rdata : '0;
  assign bus.inst_pc    = head_v ? fifo_pc_q[rd_q] : byp ? inflight_pc_q : '0;
  always_comb begin
    fetch_pc_d    = bus.redirect ? bus.redirect_pc :
                    bus.mem_req ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
    inflight_d    = bus.mem_req;
    inflight_pc_d = bus.mem_req ? fetch_pc_q : inflight_pc_q;
    kill_d        = 1'b0;
    count_d       = bus.redirect ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
    rd_d          = bus.redirect ? '0 : rd_q + PW'(pop);
    wr_d          = bus.redirect ? '0 : wr_q + PW'(push);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      count_q       <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      count_q       <= count_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && !bus.redirect && push) begin
      fifo_inst_q[wr_q] <= bus.mem_rdata;
      fifo_pc_q[wr_q]   <= inflight_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: directed checks of fetch sequencing, backpressure, redirect, wrap and reset
module tb_fetch_prefetch_buffer;
`ifdef PREFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int nreq;
  fetch_prefetch_buffer_if #(.ADDR_W(10), .DATA_W(16)) bus ();
  fetch_prefetch_buffer #(.DEPTH(4), .ADDR_W(10), .DATA_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] f(input logic [9:0] a);
    return {6'b110101, a ^ 10'h155};
  endfunction
  always @(posedge clk) bus.mem_rdata <= f(bus.mem_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic rst_v, input logic rd_v, input logic [9:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    reset           = rst_v;
    bus.redirect    = rd_v;
    bus.redirect_pc = rpc;
    bus.inst_ready  = rdy;
    @(negedge clk);
  endtask
  task automatic take(input logic [9:0] exp_pc);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.inst_valid === 1'b1) break;
    end
    chk("take_valid", 32'(bus.inst_valid), 32'd1);
    chk("take_pc", 32'(bus.inst_pc), 32'(exp_pc));
    chk("take_inst", 32'(bus.inst), 32'(f(exp_pc)));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b1;
    repeat (3) go(1, 0, 0, 1);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", 32'(bus.inst), 32'd0);
    chk("rst_inst_pc", 32'(bus.inst_pc), 32'd0);
    for (int k = 0; k < 8; k++) begin
      go(0, 0, 0, 1);
      chk("stream_mem_req", 32'(bus.mem_req), 32'd1);
      chk("stream_mem_addr", 32'(bus.mem_addr), 32'(k));
      chk("stream_valid", 32'(bus.inst_valid), 32'(k >= LAT));
      if (k >= LAT) begin
        chk("stream_pc", 32'(bus.inst_pc), 32'(k - LAT));
        chk("stream_inst", 32'(bus.inst), 32'(f(10'(k - LAT))));
      end
    end
    go(1, 0, 0, 0);
    go(0, 0, 0, 0);
    chk("bp_valid0", 32'(bus.inst_valid), 32'd0);
    chk("bp_addr0", 32'(bus.mem_addr), 32'd0);
    nreq = int'(bus.mem_req);
    for (int k = 1; k < 10; k++) begin
      go(0, 0, 0, 0);
      nreq += int'(bus.mem_req);
    end
    chk("bp_nreq", 32'(nreq), 32'd4);
    chk("bp_full_req", 32'(bus.mem_req), 32'd0);
    chk("bp_full_valid", 32'(bus.inst_valid), 32'd1);
    go(0, 0, 0, 1);
    chk("bp_rel_req", 32'(bus.mem_req), 32'd0);
    chk("bp_rel_pc", 32'(bus.inst_pc), 32'd0);
    take(10'd1);
    take(10'd2);
    take(10'd3);
    take(10'd4);
    go(1, 0, 0, 0);
    repeat (4) go(0, 0, 0, 0);
    go(0, 1, 10'h200, 0);
    chk("rd_req_gated", 32'(bus.mem_req), 32'd0);
    chk("rd_valid_ungated", 32'(bus.inst_valid), 32'd1);
    chk("rd_head_pc", 32'(bus.inst_pc), 32'd0);
    go(0, 0, 0, 0);
    chk("rd_restart_req", 32'(bus.mem_req), 32'd1);
    chk("rd_restart_addr", 32'(bus.mem_addr), 32'h200);
    chk("rd_flushed", 32'(bus.inst_valid), 32'd0);
    go(0, 0, 0, 0);
    go(0, 0, 0, 1);
    chk("rd_new_valid", 32'(bus.inst_valid), 32'd1);
    chk("rd_new_pc", 32'(bus.inst_pc), 32'h200);
    take(10'h201);
    take(10'h202);
    go(1, 0, 0, 1);
    for (int k = 0; k < 5 + LAT; k++) go(0, 0, 0, 1);
    go(0, 1, 10'h100, 1);
    chk("hs_valid", 32'(bus.inst_valid), 32'd1);
    chk("hs_pc", 32'(bus.inst_pc), 32'd5);
    chk("hs_req", 32'(bus.mem_req), 32'd0);
    go(0, 0, 0, 1);
    chk("hs_restart_addr", 32'(bus.mem_addr), 32'h100);
    take(10'h100);
    take(10'h101);
    go(0, 1, 10'd1022, 1);
    go(0, 0, 0, 1);
    take(10'd1022);
    take(10'd1023);
    take(10'd0);
    take(10'd1);
    repeat (8) go(0, 0, 0, 0);
    chk("full_req", 32'(bus.mem_req), 32'd0);
    chk("full_valid", 32'(bus.inst_valid), 32'd1);
    go(1, 0, 0, 0);
    chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
    go(0, 0, 0, 1);
    chk("mid_rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("mid_rst_req1", 32'(bus.mem_req), 32'd1);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    take(10'd0);
    take(10'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
